vote_collector: RTL
===================

Name: vote_collector

Overview:
- Upstream stage of the 5-input majority voter.
- Runs one voting round at a time: opens a window, accepts one vote per voter through a valid/ready handshake, then closes on all-present or timeout.
- Presents a registered, stable 5-bit vote vector x_o[5:1] plus a presence mask to the combinational majority stage. Pulses round_done_o when the vector is final.

Parameters:
- N_VOTERS, 5, number of voters; fixed at 5, not overridable.
- TIMEOUT_CYC, 16, maximum cycles spent in COLLECT; legal range 2..255.
- TO_W, 8, timer width; must satisfy 2**TO_W > TIMEOUT_CYC.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  request to open a new round; sampled in IDLE only
- vote_valid_i  input  1  vote offered this cycle
- vote_ready_o  output  1  block can accept a vote (high only in COLLECT)
- vote_id_i  input  3  voter index, legal 1..5
- vote_bit_i  input  1  vote value (1 = yes)
- x_o  output  5 [5:1]  registered vote vector to the majority stage
- present_o  output  5 [5:1]  voters heard this round
- round_done_o  output  1  one-cycle pulse: x_o/present_o final
- timed_out_o  output  1  round closed by timeout; held until next start
- busy_o  output  1  high in COLLECT and DONE
- err_o  output  1  one-cycle pulse: illegal or duplicate vote rejected

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; x_o, present_o, timer = 0; all 1-bit outputs = 0. Reset mid-round abandons the round and no round_done_o is produced.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - vote_ready_o = 0; x_o and present_o hold the previous round's result.
  - start_i = 1 → next cycle: x_o = 0, present_o = 0, timer = 0, timed_out_o = 0, state = COLLECT.
- COLLECT:
  - vote_ready_o = 1. A vote is accepted on the edge where vote_valid_i & vote_ready_o.
  - Legal, not-yet-present id k: x_o[k] <= vote_bit_i and present_o[k] <= 1.
  - id 0, 6 or 7: vote ignored, err_o pulses the next cycle.
  - Duplicate id (present_o[k] already 1): ignored, first vote wins, err_o pulses. An err_o pulse never changes state.
  - Timer increments every COLLECT cycle.
  - Completion: the accepted vote makes present all-ones → state = DONE next edge; timed_out_o stays 0.
  - Timeout: timer == TIMEOUT_CYC-1 and no completing vote that cycle → state = DONE and timed_out_o <= 1. Absent voters keep x_o[k] = 0 and are counted as "no".
  - A completing vote on the timeout cycle has priority: the vote is accepted and timed_out_o = 0.
  - start_i in COLLECT or DONE is ignored, with no restart.
- DONE: lasts exactly 1 cycle.
  - round_done_o = 1, vote_ready_o = 0; next state IDLE.
  - A start_i sampled in DONE is lost; the next start is taken in IDLE.
- Latency:
  - Completing vote accepted at edge t → round_done_o high in cycle t+1.
  - Minimum start-to-done: 1 (start) + 5 (votes) + 1 = round_done_o in the 7th cycle after start_i is sampled.
  - Maximum COLLECT duration: TIMEOUT_CYC cycles.
- x_o and present_o change only in COLLECT or on the start edge. They are stable from round_done_o until the next start, so the downstream majority output is valid from round_done_o onward.
- All outputs are registered or decoded from the state register only, with no combinational path from inputs to outputs.

Decomposition:
- Package vote_pkg holds:
  - the state enum {IDLE, COLLECT, DONE};
  - N_VOTERS = 5 and VOTE_ID_W = 3;
  - VOTE_ID_MIN = 1 and VOTE_ID_MAX = 5;
  - a helper function id_legal().
- One sub-module, vote_timer: clear/enable counter with a terminal flag tc_o at TIMEOUT_CYC-1, parameterised by TIMEOUT_CYC and TO_W.
- The FSM and vote registers stay in vote_collector.

Test Plan:
1. Reset mid-round: start, votes id1=1 and id2=1, assert rst → x_o = 00000, present_o = 00000, state IDLE; no round_done_o ever occurs.
2. Full round: start, then votes (1,1),(2,0),(3,1),(4,1),(5,0) on consecutive cycles → round_done_o exactly one cycle after the 5th acceptance; x_o = 01101 (bit5..1), present_o = 11111, timed_out_o = 0.
3. Duplicate and illegal ids: start, vote (3,1), then (3,0) and id 6 → two err_o pulses; x_o[3] = 1; present_o = 00100.
4. Timeout with TIMEOUT_CYC = 16: start, votes only from ids 1 and 2 (both 1) → round_done_o in COLLECT cycle 17; timed_out_o = 1; x_o = 00011; present_o = 00011.
5. Collision: 5th vote presented on the timeout cycle (timer = 15) → vote accepted, present_o = 11111, timed_out_o = 0.
6. Spurious start: start_i held high during COLLECT and DONE → no restart, votes retained; a new round begins only after IDLE with x_o cleared.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote collector: FSM states, voter id
// range, and id decode functions used by the collector datapath.
package vote_pkg;

    localparam int N_VOTERS    = 5;
    localparam int VOTE_ID_W   = 3;
    localparam logic [VOTE_ID_W-1:0] VOTE_ID_MIN = 3'd1;
    localparam logic [VOTE_ID_W-1:0] VOTE_ID_MAX = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } vote_state_e;

    function automatic logic id_legal(input logic [VOTE_ID_W-1:0] id);
        return (id >= VOTE_ID_MIN) && (id <= VOTE_ID_MAX);
    endfunction

    // Illegal ids map to an empty mask so they can never touch the vector.
    function automatic logic [N_VOTERS:1] id_mask(input logic [VOTE_ID_W-1:0] id);
        logic [N_VOTERS:1] m;
        case (id)
            3'd1:    m = 5'b00001;
            3'd2:    m = 5'b00010;
            3'd3:    m = 5'b00100;
            3'd4:    m = 5'b01000;
            3'd5:    m = 5'b10000;
            default: m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vote_timer.sv
// Round timer: clearable, enabled up-counter whose terminal flag marks the
// last permitted COLLECT cycle (count == TIMEOUT_CYC-1).
module vote_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_count;

    // Counter register; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/vote_collector.sv
// Collects one vote per voter per round and presents a registered, stable
// vote vector and presence mask to the downstream majority stage.
module vote_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 vote_valid_i,
    output logic                 vote_ready_o,
    input  logic [VOTE_ID_W-1:0] vote_id_i,
    input  logic                 vote_bit_i,
    output logic [N_VOTERS:1]    x_o,
    output logic [N_VOTERS:1]    present_o,
    output logic                 round_done_o,
    output logic                 timed_out_o,
    output logic                 busy_o,
    output logic                 err_o
);

    vote_state_e       r_state;
    vote_state_e       w_state_nxt;
    logic [N_VOTERS:1] r_x;
    logic [N_VOTERS:1] r_present;
    logic              r_timed_out;
    logic              r_err;

    logic [N_VOTERS:1] w_mask;
    logic              w_start;
    logic              w_accept;
    logic              w_take;
    logic              w_reject;
    logic              w_complete;
    logic              w_tc;

    vote_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start),
        .i_en  (r_state == COLLECT),
        .o_tc  (w_tc)
    );

    // Vote decode: first legal vote per voter wins, everything else is rejected.
    always_comb begin
        w_mask     = id_mask(vote_id_i);
        w_start    = (r_state == IDLE) && start_i;
        w_accept   = vote_valid_i && (r_state == COLLECT);
        w_take     = w_accept && id_legal(vote_id_i) && ((r_present & w_mask) == 5'b00000);
        w_reject   = w_accept && !w_take;
        w_complete = w_take && ((r_present | w_mask) == 5'b11111);
    end

    // Next-state logic; a completing vote takes priority over timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) w_state_nxt = COLLECT;
                else         w_state_nxt = IDLE;
            end
            COLLECT: begin
                if (w_complete || w_tc) w_state_nxt = DONE;
                else                    w_state_nxt = COLLECT;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Vote vector, presence mask and status flags; only start or COLLECT alter them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= 5'b00000;
            r_present   <= 5'b00000;
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_start) begin
                r_x         <= 5'b00000;
                r_present   <= 5'b00000;
                r_timed_out <= 1'b0;
            end else if (r_state == COLLECT) begin
                if (w_take) begin
                    r_x       <= (r_x & ~w_mask) | (vote_bit_i ? w_mask : 5'b00000);
                    r_present <= r_present | w_mask;
                end else begin
                    r_x       <= r_x;
                    r_present <= r_present;
                end
                r_timed_out <= w_tc && !w_complete;
            end else begin
                r_x         <= r_x;
                r_present   <= r_present;
                r_timed_out <= r_timed_out;
            end
        end
    end

    assign x_o          = r_x;
    assign present_o    = r_present;
    assign timed_out_o  = r_timed_out;
    assign err_o        = r_err;
    assign vote_ready_o = (r_state == COLLECT);
    assign round_done_o = (r_state == DONE);
    assign busy_o       = (r_state == COLLECT) || (r_state == DONE);

endmodule
